// File: rtl/nap_pkg.sv
// Shared types and default constants for the nap-session controller.
package nap_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_NAP    = 2'd1,
        PH_RING   = 2'd2,
        PH_SNOOZE = 2'd3
    } phase_e;

    localparam int DEF_NAP_W        = 12;
    localparam int DEF_SNOOZE_SEC   = 300;
    localparam int DEF_RING_MAX_SEC = 60;
    localparam int DEF_MAX_SNOOZE   = 3;

endpackage

// File: rtl/nap_scheduler_if.sv
// Button-side requests and alarm/status outputs of the nap scheduler.
interface nap_scheduler_if #(
    parameter int NAP_W = 12
);
    // No valid/ready pairs: every request (tick, go, snooze, dismiss) is a
    // one-cycle pulse taken on the rising clock edge it is high for, and all
    // status outputs are registered levels valid right after that edge.
    logic             tick;
    logic             go;
    logic [NAP_W-1:0] nap_len;
    logic             snooze;
    logic             dismiss;
    logic             alarm_start;
    logic             alarm_stop;
    logic             busy;
    logic [1:0]       phase;
    logic [NAP_W-1:0] remaining;
    logic [1:0]       snooze_cnt;

    modport master (
        output tick, go, nap_len, snooze, dismiss,
        input  alarm_start, alarm_stop, busy, phase, remaining, snooze_cnt
    );

    modport slave (
        input  tick, go, nap_len, snooze, dismiss,
        output alarm_start, alarm_stop, busy, phase, remaining, snooze_cnt
    );

endinterface

// File: rtl/nap_sec_timer.sv
// Loadable seconds down-counter; stops at zero and flags the final second.
module nap_sec_timer #(
    parameter int NAP_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [NAP_W-1:0] load_val,
    input  logic             tick,
    input  logic             clr,
    output logic [NAP_W-1:0] count,
    output logic             last
);

    logic [NAP_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - NAP_W'(1);
        end
    end

    assign count = r_count;
    assign last  = tick && (r_count == NAP_W'(1));

endmodule

// File: rtl/nap_scheduler.sv
// Nap-session controller: counts down the nap, rings the alarm, and handles
// snooze, dismiss, auto-snooze on an ignored alarm and the final give-up.
module nap_scheduler
    import nap_pkg::*;
#(
    parameter int NAP_W        = DEF_NAP_W,
    parameter int SNOOZE_SEC   = DEF_SNOOZE_SEC,
    parameter int RING_MAX_SEC = DEF_RING_MAX_SEC,
    parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
    input logic            clock,
    input logic            reset,
    nap_scheduler_if.slave bus
);

    localparam int                RING_W    = $clog2(RING_MAX_SEC + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MAX_SEC - 1);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);
    localparam logic [NAP_W-1:0]  SNZ_LOAD  = NAP_W'(SNOOZE_SEC);

    phase_e            r_phase;
    phase_e            w_phase_nxt;
    logic [RING_W-1:0] r_ring_cnt;
    logic [RING_W-1:0] w_ring_cnt_nxt;
    logic [1:0]        r_snooze_cnt;
    logic [1:0]        w_snooze_cnt_nxt;
    logic              r_busy;
    logic              r_alarm_start;
    logic              r_alarm_stop;

    logic              w_load;
    logic              w_clr;
    logic              w_last;
    logic [NAP_W-1:0]  w_load_val;
    logic [NAP_W-1:0]  w_count;

    nap_sec_timer #(
        .NAP_W (NAP_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (bus.tick),
        .clr      (w_clr),
        .count    (w_count),
        .last     (w_last)
    );

    always_comb begin
        w_phase_nxt      = r_phase;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        w_load           = 1'b0;
        w_load_val       = bus.nap_len;
        w_clr            = 1'b0;

        case (r_phase)
            PH_IDLE: begin
                if (bus.go) begin
                    w_snooze_cnt_nxt = '0;
                    if (bus.nap_len != '0) begin
                        w_phase_nxt = PH_NAP;
                        w_load      = 1'b1;
                    end else begin
                        w_phase_nxt    = PH_RING;
                        w_ring_cnt_nxt = '0;
                    end
                end
            end

            PH_NAP, PH_SNOOZE: begin
                if (bus.dismiss) begin
                    w_phase_nxt = PH_IDLE;
                    w_clr       = 1'b1;
                end else if (w_last) begin
                    // The timer reaches zero on this same edge by itself.
                    w_phase_nxt    = PH_RING;
                    w_ring_cnt_nxt = '0;
                end
            end

            PH_RING: begin
                if (bus.dismiss) begin
                    w_phase_nxt      = PH_IDLE;
                    w_snooze_cnt_nxt = '0;
                end else if (bus.snooze && (r_snooze_cnt < SNZ_MAX)) begin
                    w_phase_nxt      = PH_SNOOZE;
                    w_load           = 1'b1;
                    w_load_val       = SNZ_LOAD;
                    w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
                end else if (bus.tick) begin
                    if (r_ring_cnt == RING_LAST) begin
                        // Ignored alarm: auto-snooze while budget remains, else give up.
                        if (r_snooze_cnt < SNZ_MAX) begin
                            w_phase_nxt      = PH_SNOOZE;
                            w_load           = 1'b1;
                            w_load_val       = SNZ_LOAD;
                            w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
                        end else begin
                            w_phase_nxt = PH_IDLE;
                        end
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + RING_W'(1);
                    end
                end
            end

            default: begin
                w_phase_nxt = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= PH_IDLE;
            r_ring_cnt    <= '0;
            r_snooze_cnt  <= '0;
            r_busy        <= 1'b0;
            r_alarm_start <= 1'b0;
            r_alarm_stop  <= 1'b1;
        end else begin
            r_phase       <= w_phase_nxt;
            r_ring_cnt    <= w_ring_cnt_nxt;
            r_snooze_cnt  <= w_snooze_cnt_nxt;
            r_busy        <= (w_phase_nxt != PH_IDLE);
            r_alarm_stop  <= (w_phase_nxt != PH_RING);
            r_alarm_start <= (w_phase_nxt == PH_RING) && (r_phase != PH_RING);
        end
    end

    assign bus.phase       = r_phase;
    assign bus.busy        = r_busy;
    assign bus.alarm_start = r_alarm_start;
    assign bus.alarm_stop  = r_alarm_stop;
    assign bus.remaining   = w_count;
    assign bus.snooze_cnt  = r_snooze_cnt;

endmodule

// File: tb/tb_nap_scheduler.sv
// Directed and random checks of nap_scheduler against a session-level model.
module tb_nap_scheduler;

    localparam int NAP_W        = 8;
    localparam int SNOOZE_SEC   = 2;
    localparam int RING_MAX_SEC = 4;
    localparam int MAX_SNOOZE   = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    nap_scheduler_if #(.NAP_W(NAP_W)) bus ();

    nap_scheduler #(
        .NAP_W        (NAP_W),
        .SNOOZE_SEC   (SNOOZE_SEC),
        .RING_MAX_SEC (RING_MAX_SEC),
        .MAX_SNOOZE   (MAX_SNOOZE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference session state: 0 idle, 1 napping, 2 ringing, 3 snoozing.
    int m_phase;
    int m_rem;
    int m_scnt;
    int m_ring_secs;
    bit m_start;

    function automatic void model_reset();
        m_phase     = 0;
        m_rem       = 0;
        m_scnt      = 0;
        m_ring_secs = 0;
        m_start     = 1'b0;
    endfunction

    function automatic void model_snooze();
        m_phase = 3;
        m_rem   = SNOOZE_SEC;
        m_scnt  = m_scnt + 1;
    endfunction

    function automatic void model_step(bit t, bit g, int len, bit s, bit d);
        int prev;
        prev = m_phase;
        if (m_phase == 0) begin
            if (g) begin
                m_scnt = 0;
                if (len != 0) begin
                    m_phase = 1;
                    m_rem   = len;
                end else begin
                    m_phase     = 2;
                    m_ring_secs = 0;
                end
            end
        end else if (m_phase == 1 || m_phase == 3) begin
            if (d) begin
                m_phase = 0;
                m_rem   = 0;
            end else if (t && m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_phase     = 2;
                    m_ring_secs = 0;
                end
            end
        end else begin
            if (d) begin
                m_phase = 0;
                m_scnt  = 0;
            end else if (s && m_scnt < MAX_SNOOZE) begin
                model_snooze();
            end else if (t) begin
                m_ring_secs = m_ring_secs + 1;
                if (m_ring_secs >= RING_MAX_SEC) begin
                    if (m_scnt < MAX_SNOOZE) model_snooze();
                    else                     m_phase = 0;
                end
            end
        end
        m_start = (m_phase == 2) && (prev != 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("phase",       32'(bus.phase),       m_phase);
        chk("busy",        32'(bus.busy),        32'(m_phase != 0));
        chk("alarm_stop",  32'(bus.alarm_stop),  32'(m_phase != 2));
        chk("alarm_start", 32'(bus.alarm_start), 32'(m_start));
        chk("remaining",   32'(bus.remaining),   m_rem);
        chk("snooze_cnt",  32'(bus.snooze_cnt),  m_scnt);
    endtask

    task automatic step(input bit t, input bit g, input int len, input bit s, input bit d);
        bus.tick    = t;
        bus.go      = g;
        bus.nap_len = len[NAP_W-1:0];
        bus.snooze  = s;
        bus.dismiss = d;
        @(posedge clock);
        model_step(t, g, len, s, d);
        #1;
        chk_all();
        bus.tick    = 1'b0;
        bus.go      = 1'b0;
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
    endtask

    // One second of wall time: nine quiet cycles then the tick cycle.
    task automatic tick_secs(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 9; j++) step(0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
    endtask

    task automatic mid_cycle_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bit prev_t;
        bit t;
        bus.tick    = 1'b0;
        bus.go      = 1'b0;
        bus.nap_len = '0;
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
        reset       = 1'b1;
        model_reset();
        #12;
        chk_all();
        chk("rst_stop", 32'(bus.alarm_stop), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Basic nap of three seconds, then dismiss.
        step(0, 1, 3, 0, 0);
        chk("go_phase", 32'(bus.phase), 32'd1);
        tick_secs(3);
        chk("nap_ring_phase", 32'(bus.phase), 32'd2);
        chk("nap_ring_start", 32'(bus.alarm_start), 32'd1);
        chk("nap_ring_stop",  32'(bus.alarm_stop), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("start_one_cycle", 32'(bus.alarm_start), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("dismiss_idle", 32'(bus.phase), 32'd0);
        chk("dismiss_stop", 32'(bus.alarm_stop), 32'd1);

        // Snooze three times, then a fourth snooze is ignored.
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            chk("snooze_phase", 32'(bus.phase), 32'd3);
            tick_secs(2);
            chk("resnooze_ring", 32'(bus.phase), 32'd2);
        end
        chk("snooze_cnt_3", 32'(bus.snooze_cnt), 32'd3);
        step(0, 0, 0, 1, 0);
        chk("snooze_4_ignored", 32'(bus.phase), 32'd2);

        // Ignored alarm with snooze budget spent: give up after four seconds.
        tick_secs(3);
        chk("ring_3s", 32'(bus.phase), 32'd2);
        tick_secs(1);
        chk("give_up_idle", 32'(bus.phase), 32'd0);

        // Zero-length nap rings at once; ignored alarm auto-snoozes.
        step(0, 1, 0, 0, 0);
        chk("zero_len_ring",  32'(bus.phase), 32'd2);
        chk("zero_len_start", 32'(bus.alarm_start), 32'd1);
        tick_secs(4);
        chk("auto_snooze_phase", 32'(bus.phase), 32'd3);
        chk("auto_snooze_cnt",   32'(bus.snooze_cnt), 32'd1);

        // Collisions: dismiss beats snooze and tick.
        tick_secs(2);
        step(1, 0, 0, 1, 1);
        chk("collide_idle", 32'(bus.phase), 32'd0);
        chk("collide_cnt",  32'(bus.snooze_cnt), 32'd0);
        step(0, 1, 7, 0, 0);
        tick_secs(2);
        chk("nap_rem5", 32'(bus.remaining), 32'd5);
        step(1, 0, 0, 0, 1);
        chk("nap_dismiss_rem", 32'(bus.remaining), 32'd0);
        step(0, 1, 6, 0, 0);
        step(0, 1, 2, 0, 0);
        chk("go_in_nap_rem", 32'(bus.remaining), 32'd6);
        step(0, 0, 0, 0, 1);

        // Reset while ringing.
        step(0, 1, 0, 0, 0);
        mid_cycle_reset();
        chk("rst_ring_phase", 32'(bus.phase), 32'd0);
        chk("rst_ring_stop",  32'(bus.alarm_stop), 32'd1);

        // Random pulses against the model.
        prev_t = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            t = !prev_t && ($urandom_range(0, 3) == 0);
            prev_t = t;
            step(t, $urandom_range(0, 15) == 0, int'($urandom_range(0, 12)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
